// File: rtl/bitwise_reduce_acc.sv
// bitwise_reduce_acc
// Folds a stream of WIDTH-bit operands through one bitwise operation
// (AND/OR/XOR/NAND) and returns a single result per job.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start, op, n_ops     job request; op and n_ops latched when start is accepted in IDLE
//   in_valid, in_ready,  operand stream; an operand is consumed when in_valid && in_ready
//   in_data
//   out_valid, out_ready result handshake; result consumed when out_valid && out_ready
//   out_data             result, zero whenever out_valid is low
//   busy                 high in any state other than IDLE
module bitwise_reduce_acc #(
  parameter int WIDTH   = 8,
  parameter int MAX_OPS = 16,
  localparam int CW     = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CW-1:0]    n_ops,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    nops_q;
  logic [WIDTH-1:0] out_q;

  logic [CW-1:0]    n_clamp;
  logic [WIDTH-1:0] start_ident;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] acc_final;
  logic [WIDTH-1:0] empty_result;
  logic             last_accept;

  always_comb begin
    n_clamp = (n_ops > CW'(MAX_OPS)) ? CW'(MAX_OPS) : n_ops;

    // AND/NAND fold from all-ones, OR/XOR from zero
    start_ident = (op_e'(op) == OP_AND || op_e'(op) == OP_NAND) ? '1 : '0;
    // An empty NAND job inverts the all-ones identity, giving zero
    empty_result = (op_e'(op) == OP_NAND) ? ~start_ident : start_ident;

    acc_next = acc;
    unique case (op_q)
      OP_AND, OP_NAND: acc_next = acc & in_data;
      OP_OR:           acc_next = acc | in_data;
      OP_XOR:          acc_next = acc ^ in_data;
      default:         acc_next = acc;
    endcase

    acc_final   = (op_q == OP_NAND) ? ~acc_next : acc_next;
    last_accept = (cnt == nops_q - CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_AND;
      acc    <= '0;
      cnt    <= '0;
      nops_q <= '0;
      out_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= op_e'(op);
            acc  <= start_ident;
            cnt  <= '0;
            if (n_ops == '0) begin
              out_q <= empty_result;
              state <= DONE;
            end else begin
              nops_q <= n_clamp;
              state  <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            // The result register is loaded with the final value on the
            // last accept so out_data is registered from the first DONE cycle.
            if (last_accept) begin
              out_q <= acc_final;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_q <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_data  = out_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_bitwise_reduce_acc.sv
// Self-checking bench for bitwise_reduce_acc: directed scenarios plus
// randomized jobs, with a scoreboard queue checked by an output monitor.
module tb_bitwise_reduce_acc;

  localparam int W  = 8;
  localparam int M  = 16;
  localparam int CW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [CW-1:0] n_ops;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;

  bitwise_reduce_acc #(.WIDTH(W), .MAX_OPS(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .n_ops     (n_ops),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_seen = 0;
  int exp_acc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] opnd[0:M+3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each result bit depends only on how many of the consumed
  // operands have that bit set.
  function automatic logic [W-1:0] model(input logic [1:0] o, input int n);
    int eff;
    int ones;
    logic [W-1:0] r;
    eff = (n > M) ? M : n;
    r = '0;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int i = 0; i < eff; i++) ones += int'(opnd[i][b]);
      case (o)
        2'b00:   r[b] = (ones == eff);
        2'b01:   r[b] = (ones > 0);
        2'b10:   r[b] = ones[0];
        default: r[b] = !(ones == eff);
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor / scoreboard
  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_seen++;
      if (hold_prev && out_valid) chk("stable_data", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected no result", out_data);
        end else begin
          chk("result", out_data, exp_q.pop_front());
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic run_job(input logic [1:0] o, input int n, input int gapmax,
                         input int bp, input bit poke, input int ovr);
    int eff;
    int g;
    int t;
    eff = (n > M) ? M : n;
    t = 0;
    while (busy && t < 50) begin
      step();
      t++;
    end
    if (busy) chk("idle_timeout", busy, 0);
    start = 1'b1;
    op    = o;
    n_ops = CW'(n);
    exp_q.push_back((ovr >= 0) ? W'(ovr) : model(o, n));
    exp_acc += eff;
    step();
    start = 1'b0;
    op    = 2'($urandom);
    n_ops = CW'($urandom);
    for (int i = 0; i < eff; i++) begin
      g = $urandom_range(gapmax, 0);
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        start    = poke;
        step();
        start = 1'b0;
        chk("accum_busy", busy, 1);
      end
      in_valid = 1'b1;
      in_data  = opnd[i];
      chk("in_ready", in_ready, 1);
      if (i == eff - 1) chk("early_valid", out_valid, 0);
      step();
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
    chk("latency", out_valid, 1);
    t = 0;
    while (!out_valid && t < 40) begin
      step();
      t++;
    end
    out_ready = 1'b0;
    for (int j = 0; j < bp; j++) begin
      start = poke;
      if (poke) in_valid = 1'b1;
      chk("hold_valid", out_valid, 1);
      chk("hold_busy", busy, 1);
      step();
      in_valid = 1'b0;
    end
    start = poke;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_data", out_data, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; n_ops = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // AND fold with one-cycle result latency
    opnd[0] = 8'hFF; opnd[1] = 8'h0F; opnd[2] = 8'h3C;
    run_job(2'b00, 3, 0, 0, 1'b0, 'h0C);

    // OR / XOR / NAND
    opnd[0] = 8'h81; opnd[1] = 8'h42;
    run_job(2'b01, 2, 1, 0, 1'b0, 'hC3);
    run_job(2'b10, 2, 1, 0, 1'b0, 'hC3);
    run_job(2'b11, 2, 1, 0, 1'b0, 'hFF);
    opnd[0] = 8'hF0; opnd[1] = 8'hF0;
    run_job(2'b11, 2, 0, 0, 1'b0, 'h0F);

    // Stalls and output backpressure
    for (int i = 0; i < M + 4; i++) opnd[i] = W'($urandom);
    run_job(2'b10, 6, 3, 5, 1'b0, -1);

    // Empty jobs and count clamping
    run_job(2'b00, 0, 0, 1, 1'b0, 'hFF);
    run_job(2'b10, 0, 0, 1, 1'b0, 'h00);
    run_job(2'b01, M + 1, 1, 0, 1'b0, -1);
    run_job(2'b00, M + 1, 0, 0, 1'b0, -1);

    // Ignored inputs: in_valid in IDLE, start in ACCUM/DONE
    in_valid = 1'b1;
    in_data  = W'($urandom);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
    end
    in_valid = 1'b0;
    run_job(2'b00, 4, 2, 2, 1'b1, -1);
    run_job(2'b11, 3, 3, 3, 1'b1, -1);

    // Reset mid-job
    start = 1'b1; op = 2'b01; n_ops = CW'(4);
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      step();
    end
    in_valid = 1'b0;
    exp_acc += 2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_busy", busy, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    opnd[0] = 8'h5A;
    run_job(2'b01, 1, 0, 0, 1'b0, 'h5A);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < M + 4; i++) opnd[i] = W'($urandom);
      run_job(2'($urandom), $urandom_range(M + 3, 0), 3,
              $urandom_range(5, 0), 1'($urandom), -1);
    end

    step();
    step();
    chk("accept_count", acc_seen, exp_acc);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
